filter: RTL and testbench
=========================

Name: filter

Overview:
- 4-tap FIR filter with fixed coefficients, pipelined, on a 32-bit unsigned sample stream.
- Takes one new sample every clock. No valid/ready handshake.
- Produces y(n) = C0·x(n) + C1·x(n-1) + C2·x(n-2) + C3·x(n-3), modulo 2^WIDTH.
- Used as the basic streaming filter stage between a sample source and downstream processing.

Parameters:
- WIDTH, 32, bit width of input sample, coefficients, internal products and output.
- C0, 1, coefficient for the current sample x(n).
- C1, 2, coefficient for x(n-1).
- C2, 3, coefficient for x(n-2).
- C3, 4, coefficient for x(n-3).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- x  input  WIDTH  input sample, unsigned, captured every rising edge.
- y  output  WIDTH  filtered output, unsigned, registered.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset=0 at a rising edge) clears all state to 0 on that edge:
  - delay line d0..d3
  - product registers p0..p3
  - output register y
- While reset=0:
  - y stays 0.
  - x is ignored; it is not shifted into the delay line.
- Stage 0, delay line, every non-reset edge: d0<=x, d1<=d0, d2<=d1, d3<=d2.
- Stage 1, products, every non-reset edge: pk <= Ck·dk for k=0..3, using the dk values held before the edge.
- Stage 2, output, every non-reset edge: y <= p0+p1+p2+p3, using the pk values held before the edge.
- Timing: if x(t) is sampled at edge t, then after edge t+2, y = C0·x(t) + C1·x(t-1) + C2·x(t-2) + C3·x(t-3).
  - Latency from sampling edge to output edge is 2 clocks.
  - Throughput is 1 sample per clock.
- Arithmetic:
  - All values unsigned.
  - Each product is truncated to its low WIDTH bits.
  - The sum is truncated to WIDTH bits (wrap-around, no saturation, no overflow flag).
- History before reset release counts as zero samples.
  - The first sample after reset produces the partial sums C0·x, then C0·x'+C1·x, and so on, until 4 samples have entered.
- Reset mid-stream: the pipeline flushes completely on the reset edge.
  - After reset deasserts, behaviour is identical to a power-on start.
  - No stale samples may appear on y.
- Coefficients are elaboration-time constants; there is no runtime coefficient loading.
- x is sampled only at rising edges. Changes between edges have no effect.

Test Plan:
- Reset hold: reset=0 for 5 cycles with x toggling arbitrary values -> y=0 on every cycle.
- Impulse: release reset, then x=1 for one edge and 0 otherwise -> starting 2 edges after the impulse edge, y = 1,2,3,4, then 0 onward.
- Step: x=1 constant after reset release -> y = 1,3,6,10, then 10 steady, starting 2 edges after the first sample.
- Ramp: x increments by 1 each cycle from 0 after reset release -> once 4 samples have entered, y = 10·t-20 for sample value t; e.g. x(t)=10 gives y=80.
- Overflow: x=0xFFFFFFFF constant -> steady-state y=0xFFFFFFF6 (10·(2^32-1) mod 2^32). Intermediate values are 0xFFFFFFFF, 0xFFFFFFFD, 0xFFFFFFFA.
- Reset mid-op: run the ramp, assert reset=0 for 1 edge, then resume x=1 constant -> y=0 immediately after the reset edge, then the step sequence 1,3,6,10 with no contribution from pre-reset samples.

Source files
------------

// File: rtl/filter.sv
// Four-tap fixed-coefficient FIR stage: delay line, product registers, then a registered sum.
// All arithmetic wraps modulo 2^WIDTH. Output lags the sampling edge by two clocks.
module filter #(
  parameter int          WIDTH = 32,
  parameter int unsigned C0    = 1,
  parameter int unsigned C1    = 2,
  parameter int unsigned C2    = 3,
  parameter int unsigned C3    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] K0 = WIDTH'(C0);
  localparam logic [WIDTH-1:0] K1 = WIDTH'(C1);
  localparam logic [WIDTH-1:0] K2 = WIDTH'(C2);
  localparam logic [WIDTH-1:0] K3 = WIDTH'(C3);

  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [WIDTH-1:0] p0, p1, p2, p3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else begin
      d0 <= x;
      d1 <= d0;
      d2 <= d1;
      d3 <= d2;
    end
  end

  // Products are kept at WIDTH bits, so each one wraps before the sum is formed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      p0 <= d0 * K0;
      p1 <= d1 * K1;
      p2 <= d2 * K2;
      p3 <= d3 * K3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      y <= '0;
    end else begin
      y <= p0 + p1 + p2 + p3;
    end
  end

endmodule

// File: tb/tb_filter.sv
// Scoreboard bench for the FIR stage: a sample-history model predicts y for every edge,
// and an independent monitor compares the DUT output one step after each rising edge.
module tb_filter;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] K0 = 32'd1;
  localparam logic [WIDTH-1:0] K1 = 32'd2;
  localparam logic [WIDTH-1:0] K2 = 32'd3;
  localparam logic [WIDTH-1:0] K3 = 32'd4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y;

  int checks = 0;
  int errors = 0;
  int edge_num = 0;

  logic [WIDTH-1:0] expected_q[$];

  // Model state: the last four samples (newest first) plus the two previous edges' sums.
  logic [WIDTH-1:0] hist [4];
  logic [WIDTH-1:0] sum_prev1 = '0;
  logic [WIDTH-1:0] sum_prev2 = '0;
  bit               rst_prev1 = 1'b1;

  filter #(
    .WIDTH(WIDTH), .C0(1), .C1(2), .C2(3), .C3(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .x    (x),
    .y    (y)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] weighted_sum();
    logic [WIDTH-1:0] s;
    s = K0 * hist[0] + K1 * hist[1] + K2 * hist[2] + K3 * hist[3];
    return s;
  endfunction

  // Drive one edge's worth of input and push the y value the DUT must show after that edge.
  task automatic applyStimulus(input bit rst, input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] now_sum;
    logic [WIDTH-1:0] exp_y;
    @(negedge clk);
    reset = rst ? 1'b0 : 1'b1;
    x     = val;
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      now_sum = '0;
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = val;
      now_sum = weighted_sum();
    end
    exp_y = (rst || rst_prev1) ? '0 : sum_prev2;
    expected_q.push_back(exp_y);
    sum_prev2 = sum_prev1;
    sum_prev1 = now_sum;
    rst_prev1 = rst;
  endtask

  task automatic checkOutput(input logic [WIDTH-1:0] exp_y);
    checks++;
    if (y !== exp_y) begin
      errors++;
      $display("[TB] FAIL y_edge%0d: got %h expected %h", edge_num, y, exp_y);
    end
  endtask

  // Monitor: after each rising edge, compare y with the oldest pending prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expected_q.size() > 0) begin
        checkOutput(expected_q.pop_front());
        edge_num++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) hist[i] = '0;

    // Reset hold with x toggling.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom);

    // Impulse.
    applyStimulus(1'b0, 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0);

    // Step.
    applyStimulus(1'b1, 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd1);

    // Ramp.
    applyStimulus(1'b1, 32'd0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'(i));

    // Overflow.
    applyStimulus(1'b1, 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'hFFFF_FFFF);

    // Reset mid-stream, then step.
    applyStimulus(1'b1, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'(i + 100));
    applyStimulus(1'b1, 32'h5555_5555);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd1);

    // Random stream with occasional resets and some near-full-scale samples.
    for (int i = 0; i < 300; i++) begin
      bit rst;
      logic [WIDTH-1:0] v;
      rst = ($urandom_range(0, 19) == 0);
      v   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 15)))
                                        : $urandom;
      applyStimulus(rst, v);
    end

    // Let the last predictions drain, bounded.
    for (int i = 0; i < 10 && expected_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (expected_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expected_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
